// File: rtl/gb_mem_pkg.sv
// Shared memory-map definitions for the OAM DMA arbiter.
// Holds the DMA state encoding, the fixed bus addresses (DMA register,
// OAM base, HRAM window), the default transfer length and the source
// page remap used by the DMA engine.
package gb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam int          DMA_LENGTH   = 160;

    // Pages E0..FF fold back onto C0..DF (echo RAM), so the DMA never
    // reads the OAM/IO region it is writing into.
    function automatic logic [7:0] eff_src_hi(input logic [7:0] src);
        return (src >= 8'hE0) ? (src & 8'hDF) : src;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// Bus bundle between the CPU core / system memory side and the OAM DMA
// arbiter.
//   i_Enable          clock enable
//   i_CPU_*           CPU address, write data and strobes
//   o_CPU_Bus         read data returned to the CPU
//   o_Mem_*, i_Mem_Data   main memory bus
//   o_Hram_*, i_Hram_Data HRAM port
//   o_DMA_Active      DMA owns (or is about to own) the bus
// slave  : the arbiter side; master : the system/CPU side.
interface oam_dma_arbiter_if;
    logic        i_Enable;
    logic [15:0] i_CPU_Address;
    logic [7:0]  i_CPU_Bus;
    logic        i_CPU_Bus_Out;
    logic        i_CPU_Bus_In;
    logic [7:0]  o_CPU_Bus;
    logic [15:0] o_Mem_Address;
    logic [7:0]  o_Mem_Data;
    logic        o_Mem_Write;
    logic        o_Mem_Read;
    logic [7:0]  i_Mem_Data;
    logic [6:0]  o_Hram_Address;
    logic        o_Hram_Write;
    logic        o_Hram_Read;
    logic [7:0]  i_Hram_Data;
    logic        o_DMA_Active;

    modport slave (
        input  i_Enable, i_CPU_Address, i_CPU_Bus, i_CPU_Bus_Out, i_CPU_Bus_In,
        input  i_Mem_Data, i_Hram_Data,
        output o_CPU_Bus, o_Mem_Address, o_Mem_Data, o_Mem_Write, o_Mem_Read,
        output o_Hram_Address, o_Hram_Write, o_Hram_Read, o_DMA_Active
    );

    modport master (
        output i_Enable, i_CPU_Address, i_CPU_Bus, i_CPU_Bus_Out, i_CPU_Bus_In,
        output i_Mem_Data, i_Hram_Data,
        input  o_CPU_Bus, o_Mem_Address, o_Mem_Data, o_Mem_Write, o_Mem_Read,
        input  o_Hram_Address, o_Hram_Write, o_Hram_Read, o_DMA_Active
    );
endinterface

// File: rtl/dma_sequencer.sv
// OAM DMA sequencer: owns the transfer state, byte index, source page and
// the read-data latch, and produces the DMA side of the main bus.
//   clk, rst       clock, asynchronous active-high reset
//   enable         clock enable; all registers hold when low
//   start_hit      DMA register written this cycle (restarts any copy)
//   start_src      value written to the DMA register (source page)
//   mem_rdata      main bus read data (same cycle as dma_read)
//   state          current state
//   src_hi         last value written to the DMA register
//   dma_addr/dma_data/dma_read/dma_write   DMA bus drive
//   dma_active     high in START, READ, WRITE
module dma_sequencer
    import gb_mem_pkg::*;
#(
    parameter logic [15:0] P_DST_BASE = OAM_BASE,
    parameter int          P_LENGTH   = DMA_LENGTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start_hit,
    input  logic [7:0]  start_src,
    input  logic [7:0]  mem_rdata,
    output dma_state_t  state,
    output logic [7:0]  src_hi,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data,
    output logic        dma_read,
    output logic        dma_write,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(P_LENGTH - 1);

    dma_state_t state_reg;
    logic [7:0] idx_reg;
    logic [7:0] src_hi_reg;
    logic [7:0] data_lat_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= 8'h00;
            src_hi_reg   <= 8'h00;
            data_lat_reg <= 8'h00;
        end else if (enable) begin
            if (start_hit) begin
                // A register write always wins, even mid-copy or on the
                // final WRITE; whatever the bus is doing this cycle still
                // completes because the bus drive decodes the old state.
                src_hi_reg <= start_src;
                idx_reg    <= 8'h00;
                state_reg  <= START;
            end else begin
                case (state_reg)
                    START: state_reg <= READ;
                    READ: begin
                        data_lat_reg <= mem_rdata;
                        state_reg    <= WRITE;
                    end
                    WRITE: begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 8'd1;
                            state_reg <= READ;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Bus drive is a pure decode of the registers above.
    always_comb begin
        dma_addr  = 16'h0000;
        dma_data  = data_lat_reg;
        dma_read  = 1'b0;
        dma_write = 1'b0;
        case (state_reg)
            READ: begin
                dma_addr = {eff_src_hi(src_hi_reg), idx_reg};
                dma_read = 1'b1;
            end
            WRITE: begin
                dma_addr  = P_DST_BASE + {8'h00, idx_reg};
                dma_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign state      = state_reg;
    assign src_hi     = src_hi_reg;
    assign dma_active = (state_reg != IDLE);

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: sits between the CPU bus and the system memory decoder.
// Intercepts CPU writes to the DMA register, runs the copy to OAM through
// dma_sequencer, and while the copy owns the bus confines the CPU to HRAM.
//   i_Clk, i_Rst   clock, asynchronous active-high reset
//   bus            oam_dma_arbiter_if.slave (CPU, main bus, HRAM, status)
module oam_dma_arbiter
    import gb_mem_pkg::*;
#(
    parameter logic [15:0] P_REG_ADDR = DMA_REG_ADDR,
    parameter logic [15:0] P_DST_BASE = OAM_BASE,
    parameter int          P_LENGTH   = DMA_LENGTH
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    oam_dma_arbiter_if.slave   bus
);

    dma_state_t  state;
    logic [7:0]  src_hi;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        dma_read;
    logic        dma_write;
    logic        dma_active;

    logic        reg_sel;
    logic        hram_sel;
    logic        reg_hit;
    logic        locked;

    assign reg_sel  = (bus.i_CPU_Address == P_REG_ADDR);
    assign hram_sel = (bus.i_CPU_Address >= HRAM_LO) && (bus.i_CPU_Address <= HRAM_HI);
    assign reg_hit  = bus.i_Enable && bus.i_CPU_Bus_Out && reg_sel;
    // START still leaves the bus with the CPU; only READ/WRITE lock it out.
    assign locked   = (state == READ) || (state == WRITE);

    dma_sequencer #(
        .P_DST_BASE (P_DST_BASE),
        .P_LENGTH   (P_LENGTH)
    ) u_seq (
        .clk        (i_Clk),
        .rst        (i_Rst),
        .enable     (bus.i_Enable),
        .start_hit  (reg_hit),
        .start_src  (bus.i_CPU_Bus),
        .mem_rdata  (bus.i_Mem_Data),
        .state      (state),
        .src_hi     (src_hi),
        .dma_addr   (dma_addr),
        .dma_data   (dma_data),
        .dma_read   (dma_read),
        .dma_write  (dma_write),
        .dma_active (dma_active)
    );

    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;
    logic        mem_read;
    logic [7:0]  cpu_rdata;

    always_comb begin
        mem_addr  = bus.i_CPU_Address;
        mem_data  = bus.i_CPU_Bus;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        cpu_rdata = bus.i_Mem_Data;
        if (locked) begin
            mem_addr  = dma_addr;
            mem_data  = dma_data;
            mem_write = dma_write;
            mem_read  = dma_read;
            cpu_rdata = hram_sel ? bus.i_Hram_Data : 8'hFF;
        end else begin
            // HRAM and the DMA register never reach the main bus as writes.
            mem_write = bus.i_CPU_Bus_Out && !hram_sel && !reg_sel;
            mem_read  = bus.i_CPU_Bus_In && !hram_sel;
            if (hram_sel) begin
                cpu_rdata = bus.i_Hram_Data;
            end else if (reg_sel) begin
                cpu_rdata = src_hi;
            end
        end
    end

    assign bus.o_Mem_Address  = mem_addr;
    assign bus.o_Mem_Data     = mem_data;
    assign bus.o_Mem_Write    = mem_write;
    assign bus.o_Mem_Read     = mem_read;
    assign bus.o_CPU_Bus      = cpu_rdata;
    assign bus.o_Hram_Address = bus.i_CPU_Address[6:0];
    assign bus.o_Hram_Write   = hram_sel && bus.i_CPU_Bus_Out;
    assign bus.o_Hram_Read    = hram_sel && bus.i_CPU_Bus_In;
    assign bus.o_DMA_Active   = dma_active;

endmodule
